// File: rtl/instruction_fetch_unit_pkg.sv
// Shared core definitions for the fetch front-end.
//   - reset / interrupt vectors and the canonical NOP (addi x0,x0,0)
//   - fetch FSM state encoding
//   - opcode constants shared with the main control unit
//   - next-PC decision struct produced by fetch_next_pc
package instruction_fetch_unit_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] ISR_VECTOR   = 32'h0000_0010;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_RETI   = 7'b1111111;

    typedef enum logic {
        RUN     = 1'b0,
        LW_WAIT = 1'b1
    } fetch_state_e;

    // Everything the fetch registers load next cycle, plus the
    // combinational interrupt-accept strobe.
    typedef struct packed {
        fetch_state_e state;
        logic [31:0]  pc;
        logic [31:0]  epc;
        logic         in_isr;
        logic         irq_ack;
    } next_pc_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: control/branch/irq inputs, instruction memory port and
// the PC/ISR status outputs. master = fetch unit, slave = core/memory side.
interface instruction_fetch_unit_if;
    logic        stall_lw;
    logic        end_isr;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        irq;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_isr;
    logic        irq_ack;
    logic [31:0] epc;

    modport master (
        input  stall_lw, end_isr, branch_taken, branch_target, irq, imem_data,
        output imem_addr, instr, pc, pc_plus4, in_isr, irq_ack, epc
    );

    modport slave (
        output stall_lw, end_isr, branch_taken, branch_target, irq, imem_data,
        input  imem_addr, instr, pc, pc_plus4, in_isr, irq_ack, epc
    );
endinterface

// File: rtl/instruction_fetch_unit_next_pc.sv
// fetch_next_pc: combinational next-PC priority mux (everything but reset).
//   in : current state/pc/pc_plus4/epc/in_isr and the per-cycle events
//   out: nxt -- next register values plus the irq_ack strobe
module fetch_next_pc
    import instruction_fetch_unit_pkg::*;
(
    input  fetch_state_e state,
    input  logic [31:0]  pc,
    input  logic [31:0]  pc_plus4,
    input  logic [31:0]  epc,
    input  logic         in_isr,
    input  logic         stall_lw,
    input  logic         end_isr,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  logic         irq,
    output next_pc_t     nxt
);
    // Word alignment: the low target bits are deliberately dropped.
    logic [1:0] unused_tgt_lsb;
    assign unused_tgt_lsb = branch_target[1:0];

    always_comb begin
        nxt.state   = RUN;
        nxt.pc      = pc_plus4;
        nxt.epc     = epc;
        nxt.in_isr  = in_isr;
        nxt.irq_ack = 1'b0;
        if (state == LW_WAIT) begin
            // Same LW still on the opcode bus: its stall_lw must not
            // re-trigger, and nothing else may redirect this slot.
        end else if (stall_lw) begin
            nxt.state = LW_WAIT;
            nxt.pc    = pc;
        end else if (end_isr) begin
            // RETI outside an ISR falls through as a plain NOP.
            if (in_isr) begin
                nxt.pc     = epc;
                nxt.in_isr = 1'b0;
            end
        end else if (branch_taken) begin
            nxt.pc = {branch_target[31:2], 2'b00};
        end else if (irq && !in_isr) begin
            // Current instruction is squashed and re-fetched after RETI.
            nxt.epc     = pc;
            nxt.pc      = ISR_VECTOR;
            nxt.in_isr  = 1'b1;
            nxt.irq_ack = 1'b1;
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, fetch FSM (RUN/LW_WAIT) and interrupt
// entry/return for the single-cycle RV32 core.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : instruction_fetch_unit_if.master (events in, imem port,
//                instr to decode, pc/pc_plus4/epc/in_isr/irq_ack out)
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  epc;
    logic         in_isr;
    logic [31:0]  pc_plus4;
    next_pc_t     nxt;

    assign pc_plus4 = pc + 32'd4;

    fetch_next_pc u_next_pc (
        .state         (state),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .in_isr        (in_isr),
        .stall_lw      (bus.stall_lw),
        .end_isr       (bus.end_isr),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .irq           (bus.irq),
        .nxt           (nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            pc     <= RESET_VECTOR;
            epc    <= 32'h0;
            in_isr <= 1'b0;
        end else begin
            state  <= nxt.state;
            pc     <= nxt.pc;
            epc    <= nxt.epc;
            in_isr <= nxt.in_isr;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.pc        = pc;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.epc       = epc;
    assign bus.in_isr    = in_isr;
    assign bus.irq_ack   = nxt.irq_ack;
    // Slot being replaced by the interrupt entry goes to decode as NOP.
    assign bus.instr     = nxt.irq_ack ? NOP_INSTR : bus.imem_data;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // imem: ADDI-style word tagged with its address, {addr[23:0], 8'h93}
    assign bus.imem_data = {bus.imem_addr[23:0], 8'h93};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.stall_lw      = 1'b0;
        bus.end_isr       = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.irq           = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clr();
        do_reset();
        #1;
        // reset state
        chk("rst_pc",       bus.pc,        32'h0);
        chk("rst_addr",     bus.imem_addr, 32'h0);
        chk("rst_pc4",      bus.pc_plus4,  32'h4);
        chk("rst_in_isr",   bus.in_isr,    32'h0);
        chk("rst_irq_ack",  bus.irq_ack,   32'h0);
        chk("rst_epc",      bus.epc,       32'h0);
        chk("run_instr0",   bus.instr,     32'h0000_0093);

        // free run
        tick(); chk("run_pc4", bus.pc, 32'h4);
        tick(); chk("run_pc8", bus.pc, 32'h8);
        #1 chk("run_instr8", bus.instr, 32'h0000_0893);

        // LW at 0x8: stall_lw held for both cycles, irq raised in LW_WAIT
        bus.stall_lw = 1'b1;
        tick(); chk("lw_hold", bus.pc, 32'h8);
        bus.irq = 1'b1;
        #1 chk("lw_wait_no_ack", bus.irq_ack, 32'h0);
        tick(); chk("lw_done", bus.pc, 32'hC);
        clr();
        tick(); chk("lw_after", bus.pc, 32'h10);
        chk("lw_in_isr", bus.in_isr, 32'h0);

        // branch vs irq at pc 0x4
        do_reset();
        tick(); chk("br_pc4", bus.pc, 32'h4);
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0103; bus.irq = 1'b1;
        #1 chk("br_wins_ack", bus.irq_ack, 32'h0);
        chk("br_instr", bus.instr, 32'h0000_0493);
        tick(); chk("br_target", bus.pc, 32'h100);
        bus.branch_taken = 1'b0;
        #1 chk("br_irq_ack", bus.irq_ack, 32'h1);
        chk("br_irq_nop", bus.instr, 32'h0000_0013);
        tick(); chk("br_isr_pc", bus.pc, 32'h10);
        chk("br_epc", bus.epc, 32'h100);
        chk("br_in_isr", bus.in_isr, 32'h1);

        // irq at pc 0x20, held inside ISR, RETI, re-take
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("irq_pc20", bus.pc, 32'h20);
        bus.irq = 1'b1;
        #1 chk("irq_ack", bus.irq_ack, 32'h1);
        chk("irq_nop", bus.instr, 32'h0000_0013);
        tick(); chk("irq_vec", bus.pc, 32'h10);
        chk("irq_epc", bus.epc, 32'h20);
        chk("irq_in_isr", bus.in_isr, 32'h1);
        #1 chk("irq_nested_ack", bus.irq_ack, 32'h0);
        chk("isr_instr", bus.instr, 32'h0000_1093);
        tick(); chk("isr_pc14", bus.pc, 32'h14);
        bus.end_isr = 1'b1;
        tick(); chk("reti_pc", bus.pc, 32'h20);
        chk("reti_in_isr", bus.in_isr, 32'h0);
        bus.end_isr = 1'b0;
        #1 chk("retake_ack", bus.irq_ack, 32'h1);
        // reset in the irq_ack cycle
        reset = 1'b1;
        tick(); reset = 1'b0; clr();
        chk("rst_ack_pc", bus.pc, 32'h0);
        chk("rst_ack_in_isr", bus.in_isr, 32'h0);
        chk("rst_ack_epc", bus.epc, 32'h0);

        // end_isr outside ISR at 0x40
        bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
        tick(); chk("nop_reti_pc40", bus.pc, 32'h40);
        clr(); bus.end_isr = 1'b1;
        tick(); chk("nop_reti_pc44", bus.pc, 32'h44);
        chk("nop_reti_epc", bus.epc, 32'h0);
        chk("nop_reti_in_isr", bus.in_isr, 32'h0);

        // wrap
        clr(); bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFF;
        tick(); chk("wrap_pc", bus.pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.pc_plus4, 32'h0);
        clr();
        tick(); chk("wrap_next", bus.pc, 32'h0);

        // reset in LW_WAIT
        tick(); chk("lwr_pc4", bus.pc, 32'h4);
        bus.stall_lw = 1'b1;
        tick(); chk("lwr_hold", bus.pc, 32'h4);
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("lwr_pc", bus.pc, 32'h0);
        // state is RUN: stall_lw still high stalls again instead of advancing
        tick(); chk("lwr_run_state", bus.pc, 32'h0);
        clr();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
